// File: rtl/enter_conditioner.sv
// Pushbutton/switch input conditioner for the guessing game: synchronises the raw
// key and switches, debounces the key and emits one enter pulse with a captured guess.
module enter_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GUESS_W         = 8,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_key_raw,
  input  logic [GUESS_W-1:0] i_sw_raw,
  output logic               o_enter,
  output logic [GUESS_W-1:0] o_guess,
  output logic               o_key_level
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic KeyReleased = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    StIdle,
    StPressPend,
    StHeld,
    StReleasePend
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic enter_q, enter_d;
  logic [GUESS_W-1:0] guess_q, guess_d;

  logic key_meta_q, key_sync_q;
  logic [GUESS_W-1:0] sw_meta_q, sw_sync_q;
  logic k_s;

  // Two-flop synchronisers; the key idles at its released level out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta_q <= KeyReleased;
      key_sync_q <= KeyReleased;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= i_key_raw;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= i_sw_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Normalised key: 1 = pressed regardless of board polarity.
  assign k_s = key_sync_q ^ KEY_ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter_d = 1'b0;
    guess_d = guess_q;
    case (state_q)
      StIdle: begin
        if (k_s) begin
          state_d = StPressPend;
          cnt_d   = '0;
        end
      end
      StPressPend: begin
        if (!k_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
          cnt_d   = '0;
          enter_d = 1'b1;
          guess_d = sw_sync_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (!k_s) begin
          state_d = StReleasePend;
          cnt_d   = '0;
        end
      end
      StReleasePend: begin
        if (k_s) begin
          // Release bounce: back to held without a new pulse.
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      guess_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
      guess_q <= guess_d;
    end
  end

  assign o_enter     = enter_q;
  assign o_guess     = guess_q;
  assign o_key_level = (state_q == StHeld) || (state_q == StReleasePend);

endmodule
